// File: rtl/usb_pkg.sv
// Shared USB line-level definitions: line-state enum, dp/dm pairs for the
// full- and low-speed J/K states, and the NRZI next-state helper. Used by
// the transmit encoder and the receive decoder.
package usb_pkg;

  // Bus line state held by the encoder. The fourth code (2'b11) is never
  // produced. Consumers map it to SE0 so the lines can never show dp1/dm1.
  typedef enum logic [1:0] {
    LS_J   = 2'd0,
    LS_K   = 2'd1,
    LS_SE0 = 2'd2
  } line_state_t;

  // Line levels are packed as {dp, dm}.
  typedef logic [1:0] dpdm_t;

  // Full-speed polarity.
  localparam dpdm_t FS_J_DPDM = 2'b10;
  localparam dpdm_t FS_K_DPDM = 2'b01;

  // Low-speed polarity: J and K swap. SE0 is the same in both speeds.
  localparam dpdm_t LS_J_DPDM = 2'b01;
  localparam dpdm_t LS_K_DPDM = 2'b10;

  localparam dpdm_t SE0_DPDM  = 2'b00;

  // NRZI: a data 0 swaps J and K, and a data 1 keeps the current state.
  // The function is defined only for J and K. Any other input restarts at J,
  // which is also how an EOP is terminated.
  function automatic line_state_t nrzi_next(input line_state_t cur,
                                            input logic        data_bit);
    line_state_t nxt;
    nxt = LS_J;
    case (cur)
      LS_J:    nxt = data_bit ? LS_J : LS_K;
      LS_K:    nxt = data_bit ? LS_K : LS_J;
      default: nxt = LS_J;
    endcase
    return nxt;
  endfunction

endpackage : usb_pkg

// File: rtl/usb_line_driver.sv
// Combinational mapping from line_state_t to the D+/D- levels.
// Polarity option: define USB_ENCODER_LOW_SPEED_EN for low-speed J/K
// polarity. When it is undefined, the full-speed polarity is used.
module usb_line_driver
  import usb_pkg::*;
(
  input  line_state_t state_i,
  output logic        dp_o,
  output logic        dm_o
);

  dpdm_t j_dpdm;
  dpdm_t k_dpdm;
  dpdm_t dpdm;

`ifdef USB_ENCODER_LOW_SPEED_EN
  assign j_dpdm = LS_J_DPDM;
  assign k_dpdm = LS_K_DPDM;
`else
  assign j_dpdm = FS_J_DPDM;
  assign k_dpdm = FS_K_DPDM;
`endif

  // Decode the line state to its dp/dm pair. The unused code drives SE0.
  always_comb begin
    // NOTE: assigning a default before the case guarantees that every path
    // writes dpdm, so no latch is inferred when a new state is added.
    dpdm = SE0_DPDM;
    case (state_i)
      LS_J:    dpdm = j_dpdm;
      LS_K:    dpdm = k_dpdm;
      LS_SE0:  dpdm = SE0_DPDM;
      default: dpdm = SE0_DPDM;
    endcase
  end

  assign dp_o = dpdm[1];
  assign dm_o = dpdm[0];

endmodule : usb_line_driver

// File: rtl/usb_tx_encoder.sv
// USB 1.x transmit line encoder. It turns the bit-stuffed serial stream into
// NRZI-coded D+/D- levels and inserts SE0 for the end of packet. The only
// state is the 2-bit line-state register. The line driver decodes that
// register to the pins, so the outputs change only on strobe or reset edges.
// Polarity option: USB_ENCODER_LOW_SPEED_EN (see usb_line_driver).
module usb_tx_encoder
  import usb_pkg::*;
(
  input  logic clk,
  input  logic n_rst,         // synchronous, active-high despite its name
  input  logic serial_in,
  input  logic shift_strobe,
  input  logic send_eop,
  output logic dp_out,
  output logic dm_out
);

  line_state_t state_q;
  line_state_t state_d;

  // State register. A reset returns the line to idle J and discards any
  // pending toggle or EOP.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments, so every flop
    // samples its pre-edge inputs regardless of the order of the blocks.
    if (n_rst) begin
      state_q <= LS_J;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. The encoder advances only on a strobe, and EOP takes
  // priority over NRZI. The first bit time after an EOP is always J. NRZI
  // then restarts from that J.
  always_comb begin
    state_d = state_q;
    if (shift_strobe) begin
      if (send_eop) begin
        state_d = LS_SE0;
      end else if (state_q == LS_SE0) begin
        state_d = LS_J;
      end else begin
        state_d = nrzi_next(state_q, serial_in);
      end
    end
  end

  // Output decode. The line driver applies the build's J/K polarity.
  usb_line_driver u_line_driver (
    .state_i (state_q),
    .dp_o    (dp_out),
    .dm_o    (dm_out)
  );

  // The bus must never see dp1/dm1. The state register must never hold the
  // unused code.
  always @(posedge clk) begin
    assert (!(dp_out && dm_out))
      else $error("illegal line level dp=1 dm=1");
    assert (state_q != line_state_t'(2'b11))
      else $error("line-state register holds unused code");
  end

endmodule : usb_tx_encoder

// File: tb/tb_usb_tx_encoder.sv
// Scoreboard bench for usb_tx_encoder. A driver applies one input vector per
// cycle and pushes the dp/dm value predicted by a reference model. The model
// describes the line as "number of data zeros since the last J restart, or
// in EOP". A monitor pops the prediction after each rising edge and compares.
module tb_usb_tx_encoder;

  logic clk = 1'b0;
  logic n_rst = 1'b1;
  logic serial_in = 1'b0;
  logic shift_strobe = 1'b0;
  logic send_eop = 1'b0;
  logic dp_out;
  logic dm_out;

  int vectors = 0;
  int miscompares = 0;

  logic [1:0] exp_q [$];
  string      tag_q [$];

`ifdef USB_ENCODER_LOW_SPEED_EN
  localparam logic [1:0] J_LVL = 2'b01;
  localparam logic [1:0] K_LVL = 2'b10;
`else
  localparam logic [1:0] J_LVL = 2'b10;
  localparam logic [1:0] K_LVL = 2'b01;
`endif

  // Reference model state: the parity of the zeros sent since the line last
  // restarted from J, plus an in-EOP flag.
  int zeros_since_j = 0;
  bit in_eop = 1'b0;

  usb_tx_encoder dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .serial_in    (serial_in),
    .shift_strobe (shift_strobe),
    .send_eop     (send_eop),
    .dp_out       (dp_out),
    .dm_out       (dm_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [1:0] act,
                       input logic [1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got dp/dm=%b, expected %b at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] model_level();
    if (in_eop) return 2'b00;
    return (zeros_since_j % 2 == 0) ? J_LVL : K_LVL;
  endfunction

  // Apply one cycle of inputs, advance the model, and queue the prediction.
  task automatic drive(input bit rst, input bit strobe, input bit din,
                       input bit eop, input string tag);
    @(negedge clk);
    n_rst        = rst;
    shift_strobe = strobe;
    serial_in    = din;
    send_eop     = eop;
    if (rst) begin
      zeros_since_j = 0;
      in_eop        = 1'b0;
    end else if (strobe) begin
      if (eop) begin
        in_eop = 1'b1;
      end else if (in_eop) begin
        in_eop        = 1'b0;
        zeros_since_j = 0;
      end else if (din == 1'b0) begin
        zeros_since_j++;
      end
    end
    exp_q.push_back(model_level());
    tag_q.push_back(tag);
  endtask

  task automatic send_byte(input logic [7:0] b, input string tag);
    logic [7:0] v;
    v = b;
    for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, v[i], 1'b0, tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'(i & 1), 1'(i % 3 == 0), tag);
  endtask

  // Monitor: after each rising edge, compare the registered outputs with
  // the oldest prediction.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        check(tag_q.pop_front(), {dp_out, dm_out}, exp_q.pop_front());
      end
    end
  end

  initial begin
    // Reset, then hold with no strobes.
    drive(1'b1, 1'b0, 1'b0, 1'b0, "reset");
    drive(1'b1, 1'b1, 1'b0, 1'b1, "reset_beats_strobe");
    idle(5, "reset_idle");

    // Directed byte patterns, each from a fresh reset.
    send_byte(8'h62, "byte_62");
    drive(1'b1, 1'b0, 1'b0, 1'b0, "reset");
    send_byte(8'h06, "byte_06");
    drive(1'b1, 1'b0, 1'b0, 1'b0, "reset");
    send_byte(8'h00, "byte_00");

    // EOP sequence: two SE0 bit times, a J, then NRZI restarts from J.
    drive(1'b0, 1'b1, 1'b0, 1'b1, "eop1");
    drive(1'b0, 1'b1, 1'b1, 1'b1, "eop2");
    drive(1'b0, 1'b1, 1'b0, 1'b0, "eop_j");
    drive(1'b0, 1'b1, 1'b0, 1'b0, "post_eop_k");

    // Inputs toggle for 20 cycles without a strobe, so nothing changes.
    idle(20, "no_strobe");

    // A strobe held high for three cycles with data 0 gives three toggles.
    drive(1'b1, 1'b0, 1'b0, 1'b0, "reset");
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b0, 1'b0, "held_strobe");
    drive(1'b0, 1'b0, 1'b0, 1'b0, "held_strobe_end");

    // Reset in the middle of a packet while the line is K, and again while it is SE0.
    drive(1'b0, 1'b1, 1'b1, 1'b0, "pre_rst_k");
    drive(1'b1, 1'b1, 1'b0, 1'b1, "rst_from_k");
    drive(1'b0, 1'b1, 1'b0, 1'b0, "rst_then_k");
    drive(1'b0, 1'b1, 1'b0, 1'b1, "pre_rst_se0");
    drive(1'b1, 1'b0, 1'b0, 1'b0, "rst_from_se0");
    drive(1'b0, 1'b1, 1'b0, 1'b0, "rst_then_k2");

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(99) < 2), ($urandom_range(99) < 50),
            1'($urandom), ($urandom_range(99) < 15), "random");
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, "final");

    // Drain the scoreboard, waiting a bounded number of cycles.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d predictions left, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_usb_tx_encoder

// File: doc/usb_tx_encoder.md
# usb_tx_encoder

USB 1.x transmit-side line encoder: converts the bit-stuffed serial data stream into NRZI-coded differential D+/D− levels and drives the SE0 end-of-packet condition. It sits between the transmit shift register/bit stuffer (which provides `serial_in` and the bit-rate `shift_strobe`) and the bus output drivers. Outputs are registered and change only on strobe cycles (or reset).

## Interface
- No parameters.
- `clk`  input  1  system clock; all logic on its rising edge.
- `n_rst`  input  1  reset, synchronous, active-high. Asserted when 1 and sampled on the `clk` rising edge, despite the name.
- `serial_in`  input  1  next data bit, already bit-stuffed, LSB-first; valid when `shift_strobe`=1.
- `shift_strobe`  input  1  one-cycle pulse per USB bit time; advances the encoder.
- `send_eop`  input  1  level; when high at a strobe, the bit time is SE0 instead of data.
- `dp_out`  output  1  D+ line level.
- `dm_out`  output  1  D− line level.

## Operation
- Line states (full speed): J = dp1/dm0, K = dp0/dm1, SE0 = dp0/dm0. Outputs never show dp1/dm1.
- Reset/idle state is J.
- NRZI rule: data 0 toggles the line (J↔K), data 1 holds the current line state.
- State held: a 2-bit line-state register. Its value is {J, K, SE0}, and it drives the outputs directly.
- On a strobe with `send_eop`=1, the next state is SE0 regardless of `serial_in`. Consecutive EOP strobes keep SE0.
- On a strobe with `send_eop`=0 while the current state is SE0, the next state is J regardless of `serial_in`. This is the EOP-terminating J, and NRZI encoding restarts from J.
- On a strobe with `send_eop`=0 and current state J or K, apply the NRZI rule.
- No strobe: all state holds. `serial_in` and `send_eop` are ignored.
- Priority: `n_rst` > `send_eop` > NRZI.

## Timing
- All outputs registered. Reset value: `dp_out`=1, `dm_out`=0.
- Latency: the line state updates on the same rising edge that samples `shift_strobe`=1. The new value is visible from that edge onward and holds until the next strobe edge.
- `shift_strobe` is sampled per cycle. If it is held high for N cycles, the encoder advances N times; upstream must pulse it for one cycle.
- Reset mid-packet: on the next edge with `n_rst`=1, the state returns to J. Any pending toggle or EOP is discarded.
- Strobe in the same cycle as reset: reset wins.

## Configuration
- `USB_ENCODER_LOW_SPEED_EN`
  - Defined: low-speed polarity, with J = dp0/dm1, K = dp1/dm0, and reset/idle = dp0/dm1. SE0 is unchanged.
  - Undefined: full-speed polarity as above.
  - NRZI and EOP sequencing are identical in both builds.

## Structure
- Shared package `usb_pkg`:
  - enum `line_state_t` {LS_J, LS_K, LS_SE0}
  - constants for full/low-speed J and K dp/dm pairs, shared with the receiver decoder.
- One natural sub-module, `usb_line_driver`: combinational mapping of `line_state_t` to dp/dm, with polarity selected by the macro. The encoder holds only the state register and next-state logic.

## Test plan
- Reset → `dp_out`=1, `dm_out`=0, stable with no strobes.
- Data 0x62 LSB-first, one strobe per bit → sampled `dp_out` per bit (bit7..0) = 0b01110100. `dm_out` = ~`dp_out` every bit.
- Reset, then 0x06 → 0b10101000. Reset, then 0x00 → 0b10101010 (toggles every bit).
- After 0x00, `send_eop`=1 for two strobes → dp/dm = 0/0 after each. Then `send_eop`=0 with a strobe and `serial_in`=0 → J (1/0). The next 0 gives K (0/1).
- `serial_in` toggling with `shift_strobe`=0 for 20 cycles → no output change. Strobe held high 3 cycles with data 0 → three toggles (J→K→J→K).
- `n_rst` asserted mid-stream while the output is K or SE0 → J on the next edge. The next data 0 gives K.
